// File: rtl/adc_conv_sequencer_pkg.sv
// Shared constants, FSM state encodings and the raw-sample helpers for the
// ramp-ADC conversion sequencer.
package adc_pkg;

    localparam int FINE_BITS         = 9;
    localparam int OFFSET            = 255;
    localparam int MAX_LOG2_AVG_DFLT = 4;
    localparam int TIMEOUT_DFLT      = 64;
    localparam int RAW_W             = FINE_BITS + 1;
    localparam int RAW_SW            = FINE_BITS + 2;
    localparam int LOG2_W            = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_RISE = 3'd1;
    localparam state_t ST_WAIT_FALL = 3'd2;
    localparam state_t ST_ACCUM     = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    // Two's-complement OFFSET - fine2 + fine1; the width holds every combination.
    function automatic logic [RAW_SW-1:0] raw_diff(
        input logic [FINE_BITS-1:0] fine1,
        input logic [FINE_BITS-1:0] fine2
    );
        return RAW_SW'(OFFSET) - {2'b00, fine2} + {2'b00, fine1};
    endfunction

    // Negative raw values clamp to 0; the positive range always fits RAW_W bits.
    function automatic logic [RAW_W-1:0] clamp_raw(input logic signed [RAW_SW-1:0] raw);
        logic [RAW_W-1:0] res;
        if (raw[RAW_SW-1]) begin
            res = {RAW_W{1'b0}};
        end else begin
            res = raw[RAW_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Averaged-sample valid/ready stream between the sequencer and the readout logic.
interface adc_conv_sequencer_if;
    import adc_pkg::*;

    logic [RAW_W-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/adc_conv_sequencer_avg_accum.sv
// Accumulates clamped raw samples, counts them, and forms the averaged result
// by shifting the sum right by the averaging exponent.
module adc_avg_accum
    import adc_pkg::*;
#(
    parameter int MAX_LOG2_AVG = MAX_LOG2_AVG_DFLT
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic              i_done,
    input  logic [RAW_W-1:0]  i_raw,
    input  logic [LOG2_W-1:0] i_log2_avg,
    output logic              o_last,
    output logic [RAW_W-1:0]  o_result
);

    localparam int ACC_W = RAW_W + MAX_LOG2_AVG;
    localparam int CNT_W = MAX_LOG2_AVG + 1;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] w_target;

    // Sum and sample count; cleared at the start of a run and after each result.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_acc <= {ACC_W{1'b0}};
            r_n   <= {CNT_W{1'b0}};
        end else if (i_clear || i_done) begin
            r_acc <= {ACC_W{1'b0}};
            r_n   <= {CNT_W{1'b0}};
        end else if (i_add) begin
            r_acc <= r_acc + ACC_W'(i_raw);
            r_n   <= r_n + CNT_W'(1);
        end else begin
            r_acc <= r_acc;
            r_n   <= r_n;
        end
    end

    // o_last tells the FSM that the sample being added now completes the block.
    assign w_target = CNT_W'(1) << i_log2_avg;
    assign o_last   = ((r_n + CNT_W'(1)) == w_target);
    assign o_result = RAW_W'(r_acc >> i_log2_avg);

endmodule

// File: rtl/adc_conv_sequencer.sv
// Pairs rising/falling TDC fine codes into raw ramp-ADC samples, averages them
// and streams the result; also tracks timeouts, glitches and overruns.
module adc_conv_sequencer
    import adc_pkg::*;
#(
    parameter int MAX_LOG2_AVG = MAX_LOG2_AVG_DFLT,
    parameter int TIMEOUT      = TIMEOUT_DFLT
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [LOG2_W-1:0]     i_cfg_log2_avg,
    input  logic                  i_hit1_valid,
    input  logic [FINE_BITS-1:0]  i_fine1,
    input  logic                  i_hit2_valid,
    input  logic [FINE_BITS-1:0]  i_fine2,
    adc_conv_sequencer_if.master  io_sample,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic [7:0]            o_timeout_cnt,
    output logic [7:0]            o_glitch_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                r_state;
    logic                  r_busy;
    logic [LOG2_W-1:0]     r_log2_avg;
    logic [FINE_BITS-1:0]  r_fine1;
    logic [FINE_BITS-1:0]  r_fine2;
    logic [TMR_W-1:0]      r_timer;
    logic [7:0]            r_timeout_cnt;
    logic [7:0]            r_glitch_cnt;
    logic                  r_overrun;
    logic [RAW_W-1:0]      r_sample_data;
    logic                  r_sample_valid;

    state_t                w_state_nxt;
    logic [LOG2_W-1:0]     w_log2_clamped;
    logic                  w_acc_clear;
    logic                  w_acc_add;
    logic                  w_acc_done;
    logic                  w_last;
    logic                  w_rise_capture;
    logic                  w_in_wait_fall;
    logic                  w_fall_capture;
    logic                  w_glitch;
    logic                  w_timer_expired;
    logic                  w_timeout;
    logic                  w_handshake;
    logic [RAW_W-1:0]      w_raw;
    logic [RAW_W-1:0]      w_result;

    assign w_log2_clamped  = (i_cfg_log2_avg > LOG2_W'(MAX_LOG2_AVG)) ?
                             LOG2_W'(MAX_LOG2_AVG) : i_cfg_log2_avg;
    assign w_acc_clear     = (r_state == ST_IDLE) && i_enable;
    assign w_acc_add       = (r_state == ST_ACCUM) && i_enable;
    assign w_acc_done      = (r_state == ST_DONE);
    assign w_rise_capture  = (r_state == ST_WAIT_RISE) && i_enable && i_hit1_valid;
    assign w_in_wait_fall  = (r_state == ST_WAIT_FALL) && i_enable;
    // A simultaneous hit2 wins over hit1 in WAIT_FALL, so hit1 only counts alone.
    assign w_fall_capture  = w_in_wait_fall && i_hit2_valid;
    assign w_glitch        = w_in_wait_fall && i_hit1_valid && !i_hit2_valid;
    assign w_timer_expired = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_timeout       = w_in_wait_fall && !i_hit1_valid && !i_hit2_valid && w_timer_expired;
    assign w_handshake     = r_sample_valid && io_sample.sample_ready;
    assign w_raw           = clamp_raw($signed(raw_diff(r_fine1, r_fine2)));

    adc_avg_accum #(
        .MAX_LOG2_AVG (MAX_LOG2_AVG)
    ) u_avg_accum (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_acc_clear),
        .i_add      (w_acc_add),
        .i_done     (w_acc_done),
        .i_raw      (w_raw),
        .i_log2_avg (r_log2_avg),
        .o_last     (w_last),
        .o_result   (w_result)
    );

    // Next-state logic; dropping enable aborts any conversion in progress.
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state != ST_IDLE) && !i_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) w_state_nxt = ST_WAIT_RISE;
                    else          w_state_nxt = ST_IDLE;
                end
                ST_WAIT_RISE: begin
                    if (i_hit1_valid) w_state_nxt = ST_WAIT_FALL;
                    else              w_state_nxt = ST_WAIT_RISE;
                end
                ST_WAIT_FALL: begin
                    if (i_hit2_valid)   w_state_nxt = ST_ACCUM;
                    else if (w_timeout) w_state_nxt = ST_WAIT_RISE;
                    else                w_state_nxt = ST_WAIT_FALL;
                end
                ST_ACCUM: begin
                    if (w_last) w_state_nxt = ST_DONE;
                    else        w_state_nxt = ST_WAIT_RISE;
                end
                ST_DONE:  w_state_nxt = ST_WAIT_RISE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state, configuration latch, fine-code capture and edge-pair timer.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_log2_avg <= {LOG2_W{1'b0}};
            r_fine1    <= {FINE_BITS{1'b0}};
            r_fine2    <= {FINE_BITS{1'b0}};
            r_timer    <= {TMR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_acc_clear) r_log2_avg <= w_log2_clamped;
            else             r_log2_avg <= r_log2_avg;
            if (w_rise_capture || w_glitch) r_fine1 <= i_fine1;
            else                            r_fine1 <= r_fine1;
            if (w_fall_capture) r_fine2 <= i_fine2;
            else                r_fine2 <= r_fine2;
            if (w_rise_capture || w_glitch) r_timer <= {TMR_W{1'b0}};
            else if (w_in_wait_fall)        r_timer <= r_timer + TMR_W'(1);
            else                            r_timer <= r_timer;
        end
    end

    // Saturating event counters.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_timeout_cnt <= 8'd0;
            r_glitch_cnt  <= 8'd0;
        end else begin
            if (w_timeout && (r_timeout_cnt != 8'hFF)) r_timeout_cnt <= r_timeout_cnt + 8'd1;
            else                                       r_timeout_cnt <= r_timeout_cnt;
            if (w_glitch && (r_glitch_cnt != 8'hFF)) r_glitch_cnt <= r_glitch_cnt + 8'd1;
            else                                     r_glitch_cnt <= r_glitch_cnt;
        end
    end

    // Result holding register; a result arriving while one is still held is lost.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_sample_data  <= {RAW_W{1'b0}};
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (w_acc_done) begin
            if (!r_sample_valid || w_handshake) begin
                r_sample_data  <= w_result;
                r_sample_valid <= 1'b1;
                r_overrun      <= r_overrun;
            end else begin
                r_sample_data  <= r_sample_data;
                r_sample_valid <= r_sample_valid;
                r_overrun      <= 1'b1;
            end
        end else if (w_handshake) begin
            r_sample_data  <= r_sample_data;
            r_sample_valid <= 1'b0;
            r_overrun      <= r_overrun;
        end else begin
            r_sample_data  <= r_sample_data;
            r_sample_valid <= r_sample_valid;
            r_overrun      <= r_overrun;
        end
    end

    assign io_sample.sample_data  = r_sample_data;
    assign io_sample.sample_valid = r_sample_valid;
    assign o_busy                 = r_busy;
    assign o_overrun              = r_overrun;
    assign o_timeout_cnt          = r_timeout_cnt;
    assign o_glitch_cnt           = r_glitch_cnt;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed-vector bench for adc_conv_sequencer with hand-computed expectations.
module tb_adc_conv_sequencer;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [2:0] cfg_log2_avg;
    logic       hit1_valid;
    logic [8:0] fine1;
    logic       hit2_valid;
    logic [8:0] fine2;
    logic       busy;
    logic       overrun;
    logic [7:0] timeout_cnt;
    logic [7:0] glitch_cnt;

    int n_vec;
    int n_miss;

    adc_conv_sequencer_if u_if ();

    adc_conv_sequencer dut (
        .i_clock        (clk),
        .i_reset_n      (reset_n),
        .i_enable       (enable),
        .i_cfg_log2_avg (cfg_log2_avg),
        .i_hit1_valid   (hit1_valid),
        .i_fine1        (fine1),
        .i_hit2_valid   (hit2_valid),
        .i_fine2        (fine2),
        .io_sample      (u_if),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .o_timeout_cnt  (timeout_cnt),
        .o_glitch_cnt   (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit1(input logic [8:0] f);
        hit1_valid = 1'b1;
        fine1      = f;
        tick();
        hit1_valid = 1'b0;
    endtask

    task automatic do_hit2(input logic [8:0] f);
        hit2_valid = 1'b1;
        fine2      = f;
        tick();
        hit2_valid = 1'b0;
    endtask

    // hit1, hit2, then the ACCUM cycle; one more tick shows the result if the block completed.
    task automatic do_pair(input logic [8:0] f1, input logic [8:0] f2);
        do_hit1(f1);
        do_hit2(f2);
        tick();
    endtask

    task automatic restart(input logic [2:0] l2);
        enable = 1'b0;
        tick();
        check_val("idle_busy", 32'(busy), 32'd0);
        cfg_log2_avg = l2;
        enable       = 1'b1;
        tick();
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset_n = 1'b0; enable = 1'b0; cfg_log2_avg = 3'd0;
        hit1_valid = 1'b0; fine1 = 9'd0; hit2_valid = 1'b0; fine2 = 9'd0;
        u_if.sample_ready = 1'b1;
        tick();
        tick();
        check_val("rst_valid",   32'(u_if.sample_valid), 32'd0);
        check_val("rst_data",    32'(u_if.sample_data),  32'd0);
        check_val("rst_busy",    32'(busy),              32'd0);
        check_val("rst_overrun", 32'(overrun),           32'd0);
        check_val("rst_timeout", 32'(timeout_cnt),       32'd0);
        check_val("rst_glitch",  32'(glitch_cnt),        32'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        check_val("run_busy", 32'(busy), 32'd1);

        // 100/50 -> 305, visible exactly three cycles after hit2
        do_hit1(9'd100);
        do_hit2(9'd50);
        check_val("lat1_valid", 32'(u_if.sample_valid), 32'd0);
        tick();
        check_val("lat2_valid", 32'(u_if.sample_valid), 32'd0);
        tick();
        check_val("lat3_valid", 32'(u_if.sample_valid), 32'd1);
        check_val("basic_data", 32'(u_if.sample_data),  32'd305);
        tick();
        check_val("valid_fall", 32'(u_if.sample_valid), 32'd0);

        // clamp at both ends of the raw range
        do_pair(9'd0, 9'd511);
        tick();
        check_val("clamp_lo_valid", 32'(u_if.sample_valid), 32'd1);
        check_val("clamp_lo_data",  32'(u_if.sample_data),  32'd0);
        tick();
        do_pair(9'd511, 9'd0);
        tick();
        check_val("clamp_hi_data", 32'(u_if.sample_data), 32'd766);
        tick();

        // repeated hit1 in WAIT_FALL: second fine1 (20) is used -> 275
        do_hit1(9'd10);
        do_hit1(9'd20);
        check_val("glitch_cnt", 32'(glitch_cnt), 32'd1);
        do_hit2(9'd0);
        tick();
        tick();
        check_val("glitch_data", 32'(u_if.sample_data), 32'd275);
        tick();

        // hit1+hit2 together in WAIT_RISE: hit2 ignored, pair waits for a later hit2
        hit1_valid = 1'b1; fine1 = 9'd30; hit2_valid = 1'b1; fine2 = 9'd0;
        tick();
        hit1_valid = 1'b0; hit2_valid = 1'b0;
        tick();
        tick();
        check_val("rise_h2_ignored", 32'(u_if.sample_valid), 32'd0);
        do_hit2(9'd5);
        tick();
        tick();
        check_val("rise_h2_data", 32'(u_if.sample_data), 32'd280);
        tick();

        // hit1+hit2 together in WAIT_FALL: hit2 wins, fine1 stays 40 -> 295, no glitch
        do_hit1(9'd40);
        hit1_valid = 1'b1; fine1 = 9'd99; hit2_valid = 1'b1; fine2 = 9'd0;
        tick();
        hit1_valid = 1'b0; hit2_valid = 1'b0;
        tick();
        tick();
        check_val("both_fall_data",   32'(u_if.sample_data), 32'd295);
        check_val("both_fall_glitch", 32'(glitch_cnt),       32'd1);
        tick();

        // average of four: 300,301,302,303 -> 301
        restart(3'd2);
        for (int i = 0; i < 4; i++) begin
            do_pair(9'(45 + i), 9'd0);
            if (i == 2) check_val("avg4_pending", 32'(u_if.sample_valid), 32'd0);
        end
        tick();
        check_val("avg4_valid", 32'(u_if.sample_valid), 32'd1);
        check_val("avg4_data",  32'(u_if.sample_data),  32'd301);
        tick();

        // timeout between two pairs of a 2-average keeps the first sample: (300+301)>>1
        restart(3'd1);
        do_pair(9'd45, 9'd0);
        do_hit1(9'd50);
        repeat (63) tick();
        check_val("timeout_before", 32'(timeout_cnt), 32'd0);
        tick();
        check_val("timeout_after", 32'(timeout_cnt), 32'd1);
        check_val("timeout_busy",  32'(busy),        32'd1);
        do_pair(9'd46, 9'd0);
        tick();
        check_val("timeout_acc_data", 32'(u_if.sample_data), 32'd300);
        tick();

        // two results with ready low: first held, overrun set
        restart(3'd0);
        u_if.sample_ready = 1'b0;
        do_pair(9'd100, 9'd50);
        tick();
        check_val("hold1_data",    32'(u_if.sample_data), 32'd305);
        check_val("hold1_overrun", 32'(overrun),          32'd0);
        do_pair(9'd45, 9'd0);
        tick();
        check_val("ovr_flag",  32'(overrun),           32'd1);
        check_val("ovr_data",  32'(u_if.sample_data),  32'd305);
        check_val("ovr_valid", 32'(u_if.sample_valid), 32'd1);

        // reset in WAIT_FALL clears everything
        do_hit1(9'd7);
        reset_n = 1'b0;
        tick();
        check_val("rst2_valid",   32'(u_if.sample_valid), 32'd0);
        check_val("rst2_data",    32'(u_if.sample_data),  32'd0);
        check_val("rst2_busy",    32'(busy),              32'd0);
        check_val("rst2_overrun", 32'(overrun),           32'd0);
        check_val("rst2_timeout", 32'(timeout_cnt),       32'd0);
        check_val("rst2_glitch",  32'(glitch_cnt),        32'd0);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
